// File: rtl/sift_win_pkg.sv
// Shared constants and helpers for the SIFT horizontal/vertical pixel windows.
package sift_win_pkg;

    localparam int BORDER_ZERO   = 0;
    localparam int BORDER_REPL   = 1;
    localparam int SIFT_PIX_W    = 8;
    localparam int SIFT_WIN_TAPS = 11;

    // Fill-counter width: must hold 0..taps-1.
    function automatic int calc_cw(input int taps);
        return (taps > 2) ? $clog2(taps) : 1;
    endfunction

endpackage

// File: rtl/sift_win_fill_ctr.sv
// Per-line fill counter and window-valid flag, shared by the horizontal and vertical windows.
module sift_win_fill_ctr
    import sift_win_pkg::*;
#(
    parameter int TAPS        = SIFT_WIN_TAPS,
    parameter int BORDER_MODE = BORDER_ZERO,
    parameter int CW          = calc_cw(TAPS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic          sol_i,
    output logic [CW-1:0] fill_cnt_o,
    output logic          win_valid_o
);

    localparam logic [CW-1:0] FILL_MAX = CW'(TAPS - 1);

    logic [CW-1:0] fill_cnt_q, fill_cnt_d;
    logic          line_active_q, line_active_d;

    always_comb begin
        fill_cnt_d    = fill_cnt_q;
        line_active_d = line_active_q;
        if (en_i) begin
            if (sol_i) begin
                fill_cnt_d    = CW'(1);
                line_active_d = 1'b1;
            end else if (fill_cnt_q != FILL_MAX) begin
                fill_cnt_d = fill_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill_cnt_q    <= '0;
            line_active_q <= 1'b0;
        end else begin
            fill_cnt_q    <= fill_cnt_d;
            line_active_q <= line_active_d;
        end
    end

    // Replicate mode has a full window from the sol pixel on; zero-pad waits for real pixels.
    generate
        if (BORDER_MODE == BORDER_REPL) begin : g_valid_repl
            assign win_valid_o = en_i & (sol_i | line_active_q);
        end else begin : g_valid_zero
            assign win_valid_o = en_i & ~sol_i & line_active_q & (fill_cnt_q == FILL_MAX);
        end
    endgenerate

    assign fill_cnt_o = fill_cnt_q;

endmodule

// File: rtl/sift_tap_window.sv
// Horizontal pixel window feeding the SIFT Gaussian/DoG MAC: stallable, line-flushed delay line.
module sift_tap_window
    import sift_win_pkg::*;
#(
    parameter int DW          = SIFT_PIX_W,
    parameter int TAPS        = SIFT_WIN_TAPS,
    parameter int BORDER_MODE = BORDER_ZERO
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en_i,
    input  logic                      sol_i,
    input  logic [DW-1:0]             din,
    output logic [DW*TAPS-1:0]        dout,
    output logic                      win_valid_o,
    output logic [calc_cw(TAPS)-1:0]  fill_cnt_o
);

    localparam int CW = calc_cw(TAPS);

    generate
        if (TAPS < 2 || TAPS > 32) begin : g_bad_taps
            $error("sift_tap_window: TAPS must be within 2..32");
        end
    endgenerate

    logic          flush;
    logic [DW-1:0] border_px;

    assign flush     = en_i & sol_i;
    assign border_px = (BORDER_MODE == BORDER_REPL) ? din : '0;

    assign dout[DW-1:0] = din;

    // The registered taps hold the displayed window shifted by one position.
    generate
        for (genvar k = 1; k < TAPS; k++) begin : g_tap
            logic [DW-1:0] tap_q, tap_d;
            logic [DW-1:0] prev_px;

            if (k == 1) begin : g_first
                assign prev_px = din;
            end else begin : g_chain
                assign prev_px = flush ? border_px : g_tap[k-1].tap_q;
            end

            always_comb begin
                tap_d = tap_q;
                if (en_i) begin
                    tap_d = prev_px;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    tap_q <= '0;
                end else begin
                    tap_q <= tap_d;
                end
            end

            assign dout[k*DW +: DW] = flush ? border_px : tap_q;
        end
    endgenerate

    sift_win_fill_ctr #(
        .TAPS        (TAPS),
        .BORDER_MODE (BORDER_MODE),
        .CW          (CW)
    ) u_fill_ctr (
        .clk         (clk),
        .rst         (rst),
        .en_i        (en_i),
        .sol_i       (sol_i),
        .fill_cnt_o  (fill_cnt_o),
        .win_valid_o (win_valid_o)
    );

endmodule

// File: tb/tb_sift_tap_window.sv
// Bench for sift_tap_window: zero-pad and replicate instances share one stimulus stream.
module tb_sift_tap_window;
    import sift_win_pkg::*;

    localparam int DW   = 8;
    localparam int TAPS = 11;
    localparam int CW   = calc_cw(TAPS);
    localparam int WW   = DW * TAPS;

    logic          clk   = 1'b0;
    logic          rst   = 1'b0;
    logic          en_i  = 1'b0;
    logic          sol_i = 1'b0;
    logic [DW-1:0] din   = '0;

    logic [WW-1:0] dout_m0, dout_m1;
    logic          valid_m0, valid_m1;
    logic [CW-1:0] fill_m0, fill_m1;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    sift_tap_window #(.DW(DW), .TAPS(TAPS), .BORDER_MODE(BORDER_ZERO)) u_m0 (
        .clk(clk), .rst(rst), .en_i(en_i), .sol_i(sol_i), .din(din),
        .dout(dout_m0), .win_valid_o(valid_m0), .fill_cnt_o(fill_m0)
    );

    sift_tap_window #(.DW(DW), .TAPS(TAPS), .BORDER_MODE(BORDER_REPL)) u_m1 (
        .clk(clk), .rst(rst), .en_i(en_i), .sol_i(sol_i), .din(din),
        .dout(dout_m1), .win_valid_o(valid_m1), .fill_cnt_o(fill_m1)
    );

    // Model: pixels accepted in the current line, newest at the back.
    logic [DW-1:0] line_px[$];
    int            line_cnt = 0;
    bit            seen_sol = 1'b0;
    logic [DW-1:0] repl_px  = '0;

    task automatic model_reset();
        line_px.delete();
        line_cnt = 0;
        seen_sol = 1'b0;
        repl_px  = '0;
    endtask

    task automatic model_clock();
        if (!rst) begin
            model_reset();
        end else if (en_i) begin
            if (sol_i) begin
                line_px.delete();
                line_px.push_back(din);
                line_cnt = 1;
                seen_sol = 1'b1;
                repl_px  = din;
            end else begin
                line_px.push_back(din);
                if (line_px.size() > TAPS) void'(line_px.pop_front());
                if (line_cnt < TAPS - 1) line_cnt++;
            end
        end
    endtask

    function automatic logic [WW-1:0] exp_window(input bit repl);
        logic [WW-1:0] w;
        logic [DW-1:0] pad;
        int            n;
        w   = '0;
        n   = line_px.size();
        pad = repl ? repl_px : '0;
        w[DW-1:0] = din;
        for (int k = 1; k < TAPS; k++) begin
            if (en_i && sol_i)  w[k*DW +: DW] = repl ? din : '0;
            else if (k <= n)    w[k*DW +: DW] = line_px[n-k];
            else                w[k*DW +: DW] = pad;
        end
        return w;
    endfunction

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Every cycle, both instances are compared against the model.
    always @(negedge clk) begin
        checkOutput("m0_dout",  256'(dout_m0),  256'(exp_window(1'b0)));
        checkOutput("m1_dout",  256'(dout_m1),  256'(exp_window(1'b1)));
        checkOutput("m0_fill",  256'(fill_m0),  256'(line_cnt));
        checkOutput("m1_fill",  256'(fill_m1),  256'(line_cnt));
        checkOutput("m0_valid", 256'(valid_m0),
                    256'(en_i && !sol_i && seen_sol && line_cnt == TAPS - 1));
        checkOutput("m1_valid", 256'(valid_m1), 256'(en_i && (sol_i || seen_sol)));
    end

    // One clock: the model absorbs the inputs of the closing cycle, then new inputs go out.
    task automatic applyStimulus(input logic e, input logic s, input logic [DW-1:0] d);
        @(posedge clk);
        model_clock();
        #1;
        en_i  = e;
        sol_i = s;
        din   = d;
    endtask

    task automatic pulse_reset();
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        checkOutput("async_clear_m0", 256'(dout_m0[WW-1:DW]), 256'(0));
        checkOutput("async_clear_m1", 256'(dout_m1[WW-1:DW]), 256'(0));
        rst = 1'b1;
    endtask

    initial begin
        // Reset held with a live pixel on the input.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 8'hFF);
        #1;
        checkOutput("reset_dout",  256'(dout_m0), 256'(88'hFF));
        checkOutput("reset_valid", 256'({valid_m0, valid_m1}), 256'(0));
        checkOutput("reset_fill",  256'(fill_m0), 256'(0));
        applyStimulus(1'b0, 1'b0, 8'h00);
        rst = 1'b1;

        // Pixels before any sol: counted but never valid.
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 8'(8'h40 + i));

        // Zero-pad fill run: pixels 1..16, sol on the first.
        for (int p = 1; p <= 16; p++) begin
            applyStimulus(1'b1, p == 1, 8'(p));
            if (p == 11) begin
                #1;
                checkOutput("fill_win11",   256'(dout_m0), 256'(88'h0102030405060708090A0B));
                checkOutput("fill_valid11", 256'(valid_m0), 256'(1));
                checkOutput("fill_cnt11",   256'(fill_m0), 256'(10));
            end
        end

        // Same run with a 3-cycle stall (sol asserted while stalled must be ignored).
        for (int p = 1; p <= 16; p++) begin
            if (p == 6) for (int s = 0; s < 3; s++) applyStimulus(1'b0, s == 1, 8'hEE);
            applyStimulus(1'b1, p == 1, 8'(p));
        end
        for (int p = 17; p <= 20; p++) applyStimulus(1'b1, 1'b0, 8'(p));

        // Line restart after 20 pixels.
        applyStimulus(1'b1, 1'b1, 8'h55);
        #1;
        checkOutput("restart_taps", 256'(dout_m0), 256'(88'h55));
        checkOutput("restart_fill", 256'(fill_m0), 256'(10));
        applyStimulus(1'b1, 1'b0, 8'h56);
        #1;
        checkOutput("restart_fill_next", 256'(fill_m0), 256'(1));
        for (int p = 0; p < 12; p++) applyStimulus(1'b1, 1'b0, 8'(8'h60 + p));

        // Back-to-back sol, then a short line.
        for (int p = 0; p < 3; p++) applyStimulus(1'b1, 1'b1, 8'(8'h70 + p));
        for (int p = 0; p < 3; p++) applyStimulus(1'b1, 1'b0, 8'(8'h80 + p));

        // Replicate border.
        applyStimulus(1'b1, 1'b1, 8'h20);
        #1;
        checkOutput("repl_first",       256'(dout_m1), 256'({11{8'h20}}));
        checkOutput("repl_first_valid", 256'(valid_m1), 256'(1));
        applyStimulus(1'b1, 1'b0, 8'h21);
        #1;
        checkOutput("repl_second", 256'(dout_m1), 256'({{10{8'h20}}, 8'h21}));
        for (int p = 0; p < 5; p++) applyStimulus(1'b1, 1'b0, 8'(8'h22 + p));

        // Asynchronous reset mid-line; no window until a fresh sol.
        pulse_reset();
        for (int p = 0; p < 11; p++) applyStimulus(1'b1, 1'b0, 8'(8'h90 + p));
        #1;
        checkOutput("post_reset_valid", 256'({valid_m0, valid_m1}), 256'(0));
        for (int p = 0; p < 12; p++) applyStimulus(1'b1, p == 0, 8'(8'hA0 + p));
        applyStimulus(1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00);

        @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
